// File: rtl/fec_frame_reader.sv
// fec_frame_reader
//   Reads one FRAME_LEN-word frame out of the ping-pong buffer controller once
//   a full buffer is announced, and re-emits it as a valid/ready stream with
//   start/end-of-frame markers. A 2-entry first-word-fall-through queue absorbs
//   downstream backpressure against the 1-cycle buffer read latency.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   buf_frame_rdy_i  full buffer available (sampled only in IDLE)
//   buf_rd_en_o      read request to the buffer controller
//   buf_rd_valid_i   read data valid (1 cycle after buf_rd_en_o)
//   buf_rd_data_i    read data
//   out_valid_o      output word valid
//   out_ready_i      downstream accept
//   out_data_o       output word
//   out_sof_o        first word of frame
//   out_eof_o        last word of frame
//   busy_o           FSM not idle
//   frame_done_o     pulse in the cycle after the eof word is accepted
//   err_underrun_o   sticky: a request went unanswered
//   err_spurious_o   sticky: read data arrived with no request in flight
module fec_frame_reader #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 64,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              buf_frame_rdy_i,
  output logic              buf_rd_en_o,
  input  logic              buf_rd_valid_i,
  input  logic [DATA_W-1:0] buf_rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_sof_o,
  output logic              out_eof_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              err_underrun_o,
  output logic              err_spurious_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  localparam logic [CNT_W:0]   FL_EXT  = (CNT_W + 1)'(FRAME_LEN);
  localparam logic [CNT_W-1:0] FL_CNT  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(FRAME_LEN - 1);

  state_e                       state_q;
  logic [CNT_W-1:0]             recv_cnt_q, recv_cnt_d;
  logic                         inflight_q;
  logic [1:0]                   occ_q, occ_d, occ_ap;
  logic [1:0][DATA_W-1:0]       qdata_q, qdata_d;
  logic [1:0]                   qsof_q, qsof_d, qeof_q, qeof_d;
  logic                         frame_done_q, err_underrun_q, err_spurious_q;
  logic                         pop, push, rd_en;

  assign out_valid_o    = (occ_q != 2'd0);
  assign out_data_o     = qdata_q[0];
  // Markers are gated so a stale head entry never shows a marker when empty.
  assign out_sof_o      = out_valid_o & qsof_q[0];
  assign out_eof_o      = out_valid_o & qeof_q[0];
  assign busy_o         = (state_q != IDLE);
  assign frame_done_o   = frame_done_q;
  assign err_underrun_o = err_underrun_q;
  assign err_spurious_o = err_spurious_q;

  assign pop  = out_valid_o & out_ready_i;
  assign push = buf_rd_valid_i & inflight_q;

  // Request only if the word is still owed and the queue will have a slot
  // for it when it lands: occ + inflight - pop < 2, rearranged to avoid
  // underflow.
  assign rd_en = (state_q == READ)
               && (({1'b0, recv_cnt_q} + (CNT_W + 1)'(inflight_q)) < FL_EXT)
               && (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign buf_rd_en_o = rd_en;

  // Receive counter: cleared on frame start, saturates at FRAME_LEN.
  always_comb begin
    recv_cnt_d = recv_cnt_q;
    if (state_q == IDLE && buf_frame_rdy_i)
      recv_cnt_d = '0;
    else if (push && recv_cnt_q != FL_CNT)
      recv_cnt_d = recv_cnt_q + 1'b1;
  end

  // Shift-style FIFO: entry 0 is always the head. A pop shifts entry 1 down,
  // then a push lands in the first free slot after that shift.
  always_comb begin
    qdata_d = qdata_q;
    qsof_d  = qsof_q;
    qeof_d  = qeof_q;
    occ_ap  = occ_q - {1'b0, pop};
    occ_d   = occ_ap + {1'b0, push};
    if (pop) begin
      qdata_d[0] = qdata_q[1];
      qsof_d[0]  = qsof_q[1];
      qeof_d[0]  = qeof_q[1];
    end
    if (push) begin
      qdata_d[occ_ap[0]] = buf_rd_data_i;
      qsof_d[occ_ap[0]]  = (recv_cnt_q == '0);
      qeof_d[occ_ap[0]]  = (recv_cnt_q == FL_LAST);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      recv_cnt_q     <= '0;
      inflight_q     <= 1'b0;
      occ_q          <= '0;
      qdata_q        <= '0;
      qsof_q         <= '0;
      qeof_q         <= '0;
      frame_done_q   <= 1'b0;
      err_underrun_q <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      recv_cnt_q   <= recv_cnt_d;
      inflight_q   <= rd_en;
      occ_q        <= occ_d;
      qdata_q      <= qdata_d;
      qsof_q       <= qsof_d;
      qeof_q       <= qeof_d;
      frame_done_q <= pop & qeof_q[0];
      // Unanswered request: recv_cnt holds, so the word is simply re-requested.
      if (inflight_q && !buf_rd_valid_i) err_underrun_q <= 1'b1;
      if (buf_rd_valid_i && !inflight_q) err_spurious_q <= 1'b1;
      unique case (state_q)
        IDLE:    if (buf_frame_rdy_i)       state_q <= READ;
        READ:    if (recv_cnt_d == FL_CNT)  state_q <= DRAIN;
        DRAIN:   if (pop && qeof_q[0])      state_q <= IDLE;
        default:                            state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fec_frame_reader.sv
module tb_fec_frame_reader;
  localparam int DW = 8;
  localparam int FL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, frame_rdy = 1'b0, rd_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          rd_en, out_valid, out_sof, out_eof, busy, frame_done, err_u, err_s;
  logic [DW-1:0] out_data;

  fec_frame_reader #(.DATA_W(DW), .FRAME_LEN(FL)) dut (
    .clk_i(clk), .rst_i(rst), .buf_frame_rdy_i(frame_rdy), .buf_rd_en_o(rd_en),
    .buf_rd_valid_i(rd_valid), .buf_rd_data_i(rd_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_sof_o(out_sof),
    .out_eof_o(out_eof), .busy_o(busy), .frame_done_o(frame_done),
    .err_underrun_o(err_u), .err_spurious_o(err_s)
  );

  int checks = 0, errors = 0;
  logic [9:0] sb[$];
  int done_cnt = 0, cyc = 0, last_sof_cyc = 0, last_eof_cyc = 0;
  int ready_mode = 0, word_cnt = 0, drop_at = -1;
  logic drop_arm = 1'b0, spur_req = 1'b0, req_n = 1'b0;
  logic [7:0] word_base = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] base);
    for (int i = 0; i < FL; i++)
      sb.push_back({base + 8'(i), i == 0, i == FL - 1});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_frame();
    tick(); frame_rdy = 1'b1;
    tick(); frame_rdy = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 200) begin tick(); n++; end
    chk("done_timeout", 32'(done_cnt >= target), 1);
  endtask

  // Downstream ready: always 1, or the repeating pattern 1,0,0.
  int ph = 0;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else begin out_ready = (ph % 3 == 0); ph++; end
  end

  // Buffer controller model: answers each request one cycle later.
  always @(negedge clk) req_n = rd_en & ~rst;
  always @(posedge clk) begin : mdl
    logic rst_e;
    rst_e = rst;
    #1;
    if (rst_e) begin
      word_cnt = 0; rd_valid = 1'b0;
    end else if (spur_req) begin
      rd_valid = 1'b1; rd_data = 8'hEE; spur_req = 1'b0;
    end else if (req_n && drop_arm && word_cnt == drop_at) begin
      rd_valid = 1'b0; drop_arm = 1'b0;
    end else if (req_n) begin
      rd_valid = 1'b1; rd_data = word_base + 8'(word_cnt); word_cnt++;
    end else
      rd_valid = 1'b0;
  end

  // Monitor: scoreboard pops, stream stability, frame_done timing, occupancy bound.
  logic       stall_prev = 0, eofpop_prev = 0, push_prev = 0, pop_prev = 0, en_prev = 0;
  logic [9:0] saved = '0;
  int         occ_m = 0, infl_m = 0;
  always @(negedge clk) begin : mon
    logic pop;
    logic [9:0] exp;
    cyc++;
    if (rst) begin
      stall_prev = 0; eofpop_prev = 0; push_prev = 0; pop_prev = 0; en_prev = 0;
      occ_m = 0; infl_m = 0;
    end else begin
      pop = out_valid & out_ready;
      if (stall_prev)
        chk("stall_stable", {21'd0, out_valid, out_data, out_sof, out_eof}, {21'd0, 1'b1, saved});
      chk("frame_done_timing", 32'(frame_done), 32'(eofpop_prev));
      if (frame_done) done_cnt++;
      occ_m  = occ_m + int'(push_prev) - int'(pop_prev);
      infl_m = int'(en_prev);
      if (rd_en) chk("occ_bound", 32'(occ_m + infl_m - int'(pop) + 1 <= 2), 1);
      if (pop) begin
        if (sb.size() == 0) chk("unexpected_word", {22'd0, out_data, out_sof, out_eof}, 32'h3ff);
        else begin
          exp = sb.pop_front();
          chk("word", {22'd0, out_data, out_sof, out_eof}, {22'd0, exp});
        end
        if (out_sof) last_sof_cyc = cyc;
        if (out_eof) last_eof_cyc = cyc;
      end
      stall_prev  = out_valid & ~out_ready;
      saved       = {out_data, out_sof, out_eof};
      eofpop_prev = pop & out_eof;
      push_prev   = rd_valid & (infl_m != 0);
      pop_prev    = pop;
      en_prev     = rd_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, eof_a;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outs", {23'd0, busy, rd_en, out_valid, out_sof, out_eof, frame_done, err_u, err_s, 1'b0},
        32'd0);
    chk("reset_data", 32'(out_data), 0);

    // T1: straight frame at full rate
    word_base = 8'h10; word_cnt = 0; push_frame(8'h10);
    start_frame(); wait_done(1);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_consecutive", 32'(last_eof_cyc - last_sof_cyc), 3);
    chk("t1_busy", 32'(busy), 0);

    // T2: backpressure
    ready_mode = 1; word_base = 8'h20; word_cnt = 0; push_frame(8'h20);
    start_frame(); wait_done(2);
    ready_mode = 0;
    chk("t2_sb_empty", sb.size(), 0);
    chk("t2_no_errs", {30'd0, err_u, err_s}, 0);

    // T3: underrun on word 2
    word_base = 8'h30; word_cnt = 0; drop_at = 2; drop_arm = 1'b1; push_frame(8'h30);
    start_frame(); wait_done(3);
    chk("t3_sb_empty", sb.size(), 0);
    chk("t3_underrun", 32'(err_u), 1);
    chk("t3_spurious", 32'(err_s), 0);

    // T4: spurious data in IDLE
    spur_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_idle", {30'd0, out_valid, busy}, 0);
    end
    chk("t4_spurious", 32'(err_s), 1);

    // T5: reset mid-frame, then a clean frame
    word_base = 8'h40; word_cnt = 0; push_frame(8'h40);
    start_frame();
    n = 0;
    while (sb.size() > 2 && n < 100) begin tick(); n++; end
    chk("t5_reach_word2", 32'(sb.size() <= 2), 1);
    rst = 1'b1; sb.delete();
    tick();
    chk("t5_reset_outs", {23'd0, busy, rd_en, out_valid, out_sof, out_eof, frame_done, err_u, err_s, 1'b0},
        32'd0);
    chk("t5_reset_data", 32'(out_data), 0);
    rst = 1'b0;
    word_base = 8'h50; word_cnt = 0; push_frame(8'h50);
    start_frame(); wait_done(4);
    chk("t5_sb_empty", sb.size(), 0);

    // T6: back-to-back frames with frame_rdy held high
    word_base = 8'h60; word_cnt = 0; push_frame(8'h60); push_frame(8'h64);
    tick(); frame_rdy = 1'b1;
    wait_done(5);
    frame_rdy = 1'b0;
    eof_a = last_eof_cyc;
    wait_done(6);
    chk("t6_gap", 32'(last_sof_cyc - eof_a <= 4 && last_sof_cyc > eof_a), 1);
    chk("t6_sb_empty", sb.size(), 0);
    repeat (10) tick();
    chk("done_total", done_cnt, 6);
    chk("final_idle", {31'd0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
